// File: rtl/btb_update_ctrl_pkg.sv
// Shared types and constants for the BTB update path.
// Holds the update entry record, the issue-state encoding, the requester
// select used by the round-robin arbiter, BTB geometry and a saturating adder.
package btb_pkg;

    localparam int BTB_SETS   = 8;
    localparam int BTB_WAYS   = 2;
    localparam int BTB_ADDR_W = 32;

    // One queued BTB write: branch PC, resolved target, misprediction flag.
    typedef struct packed {
        logic [BTB_ADDR_W-1:0] pc;
        logic [BTB_ADDR_W-1:0] target;
        logic                  mispredicted;
    } btb_upd_t;

    // Issue FSM: nothing queued, draining one entry per cycle, or draining stalled.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } issue_state_e;

    // Which requester wins the next contested cycle.
    typedef enum logic {
        RR_EX = 1'b0,
        RR_ID = 1'b1
    } rr_sel_e;

    // 16-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/btb_update_ctrl_if.sv
// Request/issue bundle of the BTB update controller.
// master = the pipeline/BTB side (drives requests, receives readies and the
// update stream); slave = the controller itself.
interface btb_update_ctrl_if #(
    parameter int ADDR_W = 32
);

    // EX stage: resolved conditional branches
    logic              exValid;
    logic              exReady;
    logic [ADDR_W-1:0] exPC;
    logic [ADDR_W-1:0] exTarget;
    logic              exMispredicted;

    // ID stage: decoded direct jumps
    logic              idValid;
    logic              idReady;
    logic [ADDR_W-1:0] idPC;
    logic [ADDR_W-1:0] idTarget;
    logic              idMispredicted;

    // Write port into the BTB
    logic              update;
    logic [ADDR_W-1:0] updatePC;
    logic [ADDR_W-1:0] updateTarget;
    logic              mispredicted;

    modport master (
        output exValid, exPC, exTarget, exMispredicted,
        output idValid, idPC, idTarget, idMispredicted,
        input  exReady, idReady,
        input  update, updatePC, updateTarget, mispredicted
    );

    modport slave (
        input  exValid, exPC, exTarget, exMispredicted,
        input  idValid, idPC, idTarget, idMispredicted,
        output exReady, idReady,
        output update, updatePC, updateTarget, mispredicted
    );

endinterface

// File: rtl/btb_upd_fifo.sv
// Generic DEPTH-entry FIFO of BTB update records.
// DEPTH must be a power of two so the read/write pointers wrap for free.
// clear_i empties the queue in one cycle; push when full and pop when empty
// are ignored.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = btb_upd_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  entry_t                     wdata_i,
    input  logic                       pop_i,
    output entry_t                     rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push_ok;
    logic               pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o && !clear_i;
    assign pop_ok  = pop_i && !empty_o && !clear_i;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: state registers use <= so every flop samples pre-edge values;
        // blocking = here would make results depend on statement order.
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately left out of reset; occupancy says which
        // slots are valid, and an unreset array maps onto plain RAM/flops.
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB update controller: round-robin arbitration between the EX and ID update
// requesters, a DEPTH-entry FIFO, and an issue FSM that drains at most one
// entry per cycle into the single BTB write port, honouring hold and flush.
// Optional build macro BTB_UPD_STATS_EN adds saturating issue / flush-drop /
// contention counters.
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    btb_update_ctrl_if.slave           bus,
    input  logic                       hold,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] pending
`ifdef BTB_UPD_STATS_EN
    ,
    output logic [15:0]                issuedCnt,
    output logic [15:0]                flushDropCnt,
    output logic [15:0]                contendCnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    // Same layout as btb_upd_t, sized by this instance's address width.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] target;
        logic              mispredicted;
    } upd_t;

    issue_state_e      state_q, state_d;
    rr_sel_e           rr_q, rr_d;

    logic              can_accept;
    logic              both_valid;
    logic              contested;
    logic              ex_grant;
    logic              id_grant;
    logic              push;
    logic              pop;
    upd_t              fifo_wdata;
    upd_t              fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    logic              update_q;
    logic [ADDR_W-1:0] upd_pc_q;
    logic [ADDR_W-1:0] upd_target_q;
    logic              upd_mispred_q;

    btb_upd_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (upd_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Acceptance and round-robin arbitration; no bypass of a full queue.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        can_accept  = rst && !flush && !fifo_full;
        both_valid  = bus.exValid && bus.idValid;
        contested   = both_valid && can_accept;
        bus.exReady = can_accept && !(both_valid && (rr_q == RR_ID));
        bus.idReady = can_accept && !(both_valid && (rr_q == RR_EX));
        ex_grant    = bus.exValid && bus.exReady;
        id_grant    = bus.idValid && bus.idReady;
        push        = ex_grant || id_grant;
        rr_d        = rr_q;
        fifo_wdata  = '{pc: bus.idPC, target: bus.idTarget, mispredicted: bus.idMispredicted};
        if (ex_grant) begin
            fifo_wdata = '{pc: bus.exPC, target: bus.exTarget, mispredicted: bus.exMispredicted};
        end
        if (contested) begin
            rr_d = (rr_q == RR_EX) ? RR_ID : RR_EX;
        end
    end

    // Issue FSM next state and pop decision.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (push) state_d = hold ? HOLD : ISSUE;
            end
            ISSUE, HOLD: begin
                pop = !hold && !fifo_empty;
                if (pop && !push && (fifo_count == CNT_W'(1))) begin
                    state_d = IDLE;
                end else begin
                    state_d = hold ? HOLD : ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            pop     = 1'b0;
        end
    end

    // FSM state and arbiter pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rr_q    <= RR_EX;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    // BTB write port: strobe for one cycle per popped entry, data held otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            update_q      <= 1'b0;
            upd_pc_q      <= '0;
            upd_target_q  <= '0;
            upd_mispred_q <= 1'b0;
        end else begin
            update_q <= pop;
            if (pop) begin
                upd_pc_q      <= fifo_rdata.pc;
                upd_target_q  <= fifo_rdata.target;
                upd_mispred_q <= fifo_rdata.mispredicted;
            end
        end
    end

    assign bus.update       = update_q;
    assign bus.updatePC     = upd_pc_q;
    assign bus.updateTarget = upd_target_q;
    assign bus.mispredicted = upd_mispred_q;
    assign pending          = fifo_count;

`ifdef BTB_UPD_STATS_EN
    logic [15:0] issued_q;
    logic [15:0] flush_drop_q;
    logic [15:0] contend_q;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            issued_q     <= '0;
            flush_drop_q <= '0;
            contend_q    <= '0;
        end else begin
            if (update_q)  issued_q  <= sat_add16(issued_q, 16'd1);
            if (contested) contend_q <= sat_add16(contend_q, 16'd1);
            if (flush)     flush_drop_q <= sat_add16(flush_drop_q, 16'(fifo_count));
        end
    end

    assign issuedCnt    = issued_q;
    assign flushDropCnt = flush_drop_q;
    assign contendCnt   = contend_q;
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_btb_update_ctrl;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       hold;
    logic       flush;
    logic [2:0] pending;
`ifdef BTB_UPD_STATS_EN
    logic [15:0] issuedCnt, flushDropCnt, contendCnt;
`endif

    btb_update_ctrl_if #(.ADDR_W(ADDR_W)) bus_if ();

    btb_update_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_if),
        .hold         (hold),
        .flush        (flush),
        .pending      (pending)
`ifdef BTB_UPD_STATS_EN
        ,
        .issuedCnt    (issuedCnt),
        .flushDropCnt (flushDropCnt),
        .contendCnt   (contendCnt)
`endif
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Reference model: an ordered queue of accepted entries plus the
    // "who wins the next tie" flag and the last value seen on the write port.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic        mis;
    } ent_t;

    ent_t        mq[$];
    logic        m_id_turn = 1'b0;
    logic        m_upd = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_tg = '0;
    logic        m_mis = 1'b0;
    logic        seen_ex_rdy, seen_id_rdy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic [31:0] tg, input logic m);
        bus_if.exValid = v; bus_if.exPC = pc; bus_if.exTarget = tg; bus_if.exMispredicted = m;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] tg, input logic m);
        bus_if.idValid = v; bus_if.idPC = pc; bus_if.idTarget = tg; bus_if.idMispredicted = m;
    endtask

    task automatic set_ctl(input logic h, input logic f, input logic r);
        hold = h; flush = f; rst = r;
    endtask

    task automatic idle();
        set_ex(1'b0, '0, '0, 1'b0);
        set_id(1'b0, '0, '0, 1'b0);
    endtask

    // One clock: check readies mid-cycle, advance the model at the edge,
    // then check the registered outputs just after it.
    task automatic step();
        logic ok, both, e_ex, e_id;
        ent_t e;
        @(negedge clk);
        ok   = rst && !flush && (mq.size() < DEPTH);
        both = bus_if.exValid && bus_if.idValid;
        e_ex = ok && !(both && m_id_turn);
        e_id = ok && !(both && !m_id_turn);
        seen_ex_rdy = bus_if.exReady;
        seen_id_rdy = bus_if.idReady;
        check("exReady", bus_if.exReady, e_ex);
        check("idReady", bus_if.idReady, e_id);
        @(posedge clk);
        if (!rst) begin
            mq.delete();
            m_id_turn = 1'b0;
            m_upd = 1'b0; m_pc = '0; m_tg = '0; m_mis = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_upd = 1'b0;
        end else begin
            m_upd = 1'b0;
            if (mq.size() > 0 && !hold) begin
                e = mq.pop_front();
                m_upd = 1'b1; m_pc = e.pc; m_tg = e.target; m_mis = e.mis;
            end
            if (bus_if.exValid && e_ex)
                mq.push_back('{bus_if.exPC, bus_if.exTarget, bus_if.exMispredicted});
            else if (bus_if.idValid && e_id)
                mq.push_back('{bus_if.idPC, bus_if.idTarget, bus_if.idMispredicted});
            if (both && ok) m_id_turn = !m_id_turn;
        end
        #1;
        check("update", bus_if.update, m_upd);
        check("updatePC", bus_if.updatePC, m_pc);
        check("updateTarget", bus_if.updateTarget, m_tg);
        check("mispredicted", bus_if.mispredicted, m_mis);
        check("pending", pending, mq.size());
    endtask

    typedef struct {
        logic        ex_v;
        logic [31:0] ex_pc;
        logic [31:0] ex_tg;
        logic        id_v;
        logic [31:0] id_pc;
        logic [31:0] id_tg;
        logic        exp_ex_rdy;
        logic        exp_id_rdy;
        logic        exp_upd;
        logic [31:0] exp_pc;
        int          exp_pending;
    } vec_t;

    vec_t vecs[9];

    initial begin : main
        int n_upd;
        logic [31:0] got_pc[$];

        vecs[0] = '{1'b1, 32'h000A0000, 32'h000B0000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h00000000, 1};
        vecs[1] = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h000A0000, 0};
        vecs[2] = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h000A0000, 0};
        vecs[3] = '{1'b1, 32'h000A0004, 32'h000B0004, 1'b1, 32'h000A0024, 32'h000B0024, 1'b1, 1'b0, 1'b0, 32'h000A0000, 1};
        vecs[4] = '{1'b1, 32'h000A0004, 32'h000B0004, 1'b1, 32'h000A0024, 32'h000B0024, 1'b0, 1'b1, 1'b1, 32'h000A0004, 1};
        vecs[5] = '{1'b1, 32'h000A0004, 32'h000B0004, 1'b1, 32'h000A0024, 32'h000B0024, 1'b1, 1'b0, 1'b1, 32'h000A0024, 1};
        vecs[6] = '{1'b1, 32'h000A0004, 32'h000B0004, 1'b1, 32'h000A0024, 32'h000B0024, 1'b0, 1'b1, 1'b1, 32'h000A0004, 1};
        vecs[7] = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h000A0024, 0};
        vecs[8] = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h000A0024, 0};

        // Reset
        idle();
        set_ctl(1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        step();
        step();
        set_ctl(1'b0, 1'b0, 1'b1);

        // Directed table: single request latency, then alternating contention
        for (int i = 0; i < 9; i++) begin
            set_ex(vecs[i].ex_v, vecs[i].ex_pc, vecs[i].ex_tg, 1'b0);
            set_id(vecs[i].id_v, vecs[i].id_pc, vecs[i].id_tg, 1'b1);
            step();
            check($sformatf("vec%0d exReady", i), seen_ex_rdy, vecs[i].exp_ex_rdy);
            check($sformatf("vec%0d idReady", i), seen_id_rdy, vecs[i].exp_id_rdy);
            check($sformatf("vec%0d update", i), bus_if.update, vecs[i].exp_upd);
            check($sformatf("vec%0d updatePC", i), bus_if.updatePC, vecs[i].exp_pc);
            check($sformatf("vec%0d pending", i), pending, vecs[i].exp_pending);
        end

        // Enqueue and pop in the same cycle with two queued
        set_ctl(1'b1, 1'b0, 1'b1);
        set_ex(1'b1, 32'h000C0000, 32'h000D0000, 1'b0); step();
        set_ex(1'b1, 32'h000C0004, 32'h000D0004, 1'b1); step();
        check("enqpop pending before", pending, 2);
        set_ctl(1'b0, 1'b0, 1'b1);
        set_ex(1'b1, 32'h000C0008, 32'h000D0008, 1'b0); step();
        check("enqpop pending kept", pending, 2);
        check("enqpop first out", bus_if.updatePC, 32'h000C0000);
        idle(); step();
        check("enqpop second out", bus_if.updatePC, 32'h000C0004);
        step();
        check("enqpop third out", bus_if.updatePC, 32'h000C0008);
        step();

        // Hold with five pushes into a four-deep queue, then drain
        set_ctl(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            set_ex(1'b1, 32'h000D0000 + 32'(4 * i), 32'h000E0000 + 32'(i), 1'b0);
            step();
        end
        check("hold full exReady", seen_ex_rdy, 1'b0);
        check("hold pending", pending, 4);
        idle();
        set_ctl(1'b0, 1'b0, 1'b1);
        n_upd = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus_if.update) begin
                n_upd++;
                got_pc.push_back(bus_if.updatePC);
            end
        end
        check("hold drain count", n_upd, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("hold drain order %0d", i),
                  (got_pc.size() > i) ? got_pc[i] : 32'hFFFFFFFF, 32'h000D0000 + 32'(4 * i));
        end

        // Flush with three queued
        set_ctl(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            set_ex(1'b1, 32'h000E0000 + 32'(4 * i), 32'h000F0000, 1'b0);
            step();
        end
        check("flush pending before", pending, 3);
        set_ctl(1'b1, 1'b1, 1'b1);
        step();
        check("flush pending", pending, 0);
        check("flush update", bus_if.update, 1'b0);
`ifdef BTB_UPD_STATS_EN
        check("flushDropCnt", flushDropCnt, 16'd3);
`endif
        idle();
        set_ctl(1'b0, 1'b0, 1'b1);
        step();
        check("post-flush update", bus_if.update, 1'b0);

        // Reset while issuing
        set_ctl(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            set_ex(1'b1, 32'h00100000 + 32'(4 * i), 32'h00110000, 1'b1);
            step();
        end
        idle();
        set_ctl(1'b0, 1'b0, 1'b1);
        step();
        check("pre-reset update", bus_if.update, 1'b1);
        set_ctl(1'b0, 1'b0, 1'b0);
        step();
        check("reset update", bus_if.update, 1'b0);
        check("reset updatePC", bus_if.updatePC, 32'h0);
        check("reset pending", pending, 0);
        set_ctl(1'b0, 1'b0, 1'b1);
        n_upd = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus_if.update) n_upd++;
        end
        check("post-reset updates", n_upd, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            set_ex($urandom_range(0, 1) == 1, $urandom, $urandom, $urandom_range(0, 1) == 1);
            set_id($urandom_range(0, 1) == 1, $urandom, $urandom, $urandom_range(0, 1) == 1);
            set_ctl($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 49) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
